// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchical fan-out node and its leaf workers.
package hier_node_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   // Width of a child index, never below one bit so a single-child node still has a legal vector.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hier_leaf_worker.sv
// Leaf worker: loads a work count, counts it down to zero and reports done while active.
module hier_leaf_worker #(
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [LW-1:0] load_val,
   input  logic          clear,
   output logic          active_o,
   output logic          done_o
);

   logic          active_q;
   logic [LW-1:0] count_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         count_q  <= '0;
      end else if (clear) begin
         active_q <= 1'b0;
         count_q  <= '0;
      end else if (load) begin
         active_q <= 1'b1;
         count_q  <= load_val;
      end else if (active_q && (count_q != '0)) begin
         count_q <= count_q - LW'(1);
      end
   end

   assign active_o = active_q;
   assign done_o   = active_q && (count_q == '0);

endmodule

// File: rtl/hier_fanout_node.sv
// Hierarchy node: broadcasts one command to a masked set of leaf workers and returns an aggregated response.
module hier_fanout_node #(
   parameter int NUM_CHILD = 5,
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [DATA_W-1:0]    req_data,
   input  logic [NUM_CHILD-1:0] req_mask,
   input  logic                 abort,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [NUM_CHILD-1:0] resp_mask,
   output logic [CNT_W-1:0]     resp_cycles,
   output logic                 resp_aborted
);

   import hier_node_pkg::*;

   localparam int IDX_W = idx_width(NUM_CHILD);
   localparam int LW    = DATA_W + IDX_W;

   state_t               state_q, state_d;
   logic [NUM_CHILD-1:0] mask_q;
   logic [NUM_CHILD-1:0] leaf_active, leaf_done, leaf_load;
   logic                 leaf_clear;
   logic [CNT_W-1:0]     run_cnt_q, run_cnt_inc;
   logic                 accept, all_done;
   logic                 cap_done, cap_abort, cap_empty;

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_REPORT);
   assign accept     = req_valid && req_ready;

   // Saturating increment; also the reported cycle count since the current RUN cycle is included.
   assign run_cnt_inc = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_W'(1);

   // A leaf that was never loaded does not hold up completion.
   assign all_done = &(~leaf_active | leaf_done);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      leaf_load  = '0;
      leaf_clear = 1'b0;
      cap_done   = 1'b0;
      cap_abort  = 1'b0;
      cap_empty  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_mask != '0) begin
                  leaf_load = req_mask;
                  state_d   = ST_RUN;
               end else begin
                  cap_empty = 1'b1;
                  state_d   = ST_REPORT;
               end
            end
         end
         ST_RUN: begin
            // Completion outranks a coincident abort.
            if (all_done) begin
               cap_done = 1'b1;
               state_d  = ST_REPORT;
            end else if (abort) begin
               cap_abort  = 1'b1;
               leaf_clear = 1'b1;
               state_d    = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (resp_ready) begin
               leaf_clear = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         run_cnt_q    <= '0;
         resp_mask    <= '0;
         resp_cycles  <= '0;
         resp_aborted <= 1'b0;
      end else begin
         state_q <= state_d;

         if (accept) begin
            mask_q    <= req_mask;
            run_cnt_q <= '0;
         end else if (state_q == ST_RUN) begin
            run_cnt_q <= run_cnt_inc;
         end

         if (cap_empty) begin
            resp_mask    <= '0;
            resp_cycles  <= '0;
            resp_aborted <= 1'b0;
         end else if (cap_done) begin
            resp_mask    <= mask_q;
            resp_cycles  <= run_cnt_inc;
            resp_aborted <= 1'b0;
         end else if (cap_abort) begin
            resp_mask    <= leaf_active & leaf_done;
            resp_cycles  <= run_cnt_inc;
            resp_aborted <= 1'b1;
         end
      end
   end

   // Leaf i works for req_data + i cycles; LW leaves room for the index so the sum cannot wrap.
   for (genvar i = 0; i < NUM_CHILD; i++) begin : g_leaf
      logic [LW-1:0] load_val;
      assign load_val = LW'(req_data) + LW'(i);

      hier_leaf_worker #(
         .LW(LW)
      ) u_leaf (
         .clk      (clk),
         .rst      (rst),
         .load     (leaf_load[i]),
         .load_val (load_val),
         .clear    (leaf_clear),
         .active_o (leaf_active[i]),
         .done_o   (leaf_done[i])
      );
   end

   a_ready_valid_excl: assert property (@(posedge clk) !(req_ready && resp_valid));

   a_resp_stable: assert property (@(posedge clk) disable iff (rst)
      (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_mask) &&
                                       $stable(resp_cycles) && $stable(resp_aborted)));

endmodule

// File: tb/tb_hier_fanout_node.sv
// Self-checking bench for hier_fanout_node: directed vector table, corner sequences and a randomized model check.
module tb_hier_fanout_node;

   localparam int NC = 5;
   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [DW-1:0] req_data = '0;
   logic [NC-1:0] req_mask = '0;
   logic          abort = 1'b0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [NC-1:0] resp_mask;
   logic [CW-1:0] resp_cycles;
   logic          resp_aborted;

   // Second instance with a 3-bit counter for the saturation case.
   logic          s_req_valid = 1'b0;
   logic          s_req_ready;
   logic [DW-1:0] s_req_data = '0;
   logic [NC-1:0] s_req_mask = '0;
   logic          s_resp_valid;
   logic          s_resp_ready = 1'b0;
   logic [NC-1:0] s_resp_mask;
   logic [2:0]    s_resp_cycles;
   logic          s_resp_aborted;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hier_fanout_node #(.NUM_CHILD(NC), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_mask(req_mask), .abort(abort),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_mask(resp_mask),
      .resp_cycles(resp_cycles), .resp_aborted(resp_aborted)
   );

   hier_fanout_node #(.NUM_CHILD(NC), .DATA_W(DW), .CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
      .req_data(s_req_data), .req_mask(s_req_mask), .abort(1'b0),
      .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_mask(s_resp_mask),
      .resp_cycles(s_resp_cycles), .resp_aborted(s_resp_aborted)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [NC-1:0] mask;
      int            ak;     // RUN cycle index carrying the abort pulse, -1 for none
      logic [NC-1:0] em;
      int            ecyc;
      bit            eab;
      int            elat;   // cycles from accept edge to first resp_valid
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: each selected leaf i needs data+i cycles of work; the run ends one cycle after the
   // slowest leaf reaches zero, unless an abort lands strictly before that point.
   function automatic void model(input int data, input logic [NC-1:0] mask, input int ak,
                                 output logic [NC-1:0] em, output int ecyc,
                                 output bit eab, output int elat);
      int maxl = -1;
      for (int i = 0; i < NC; i++)
         if (mask[i] && (data + i) > maxl) maxl = data + i;
      em = '0;
      if (mask == '0) begin
         ecyc = 0; eab = 0; elat = 1;
      end else if (ak >= 0 && ak < maxl) begin
         for (int i = 0; i < NC; i++)
            if (mask[i] && (data + i) <= ak) em[i] = 1'b1;
         ecyc = ak + 1; eab = 1; elat = ak + 2;
      end else begin
         em = mask; ecyc = maxl + 1; eab = 0; elat = maxl + 2;
      end
   endfunction

   // Called #1 after a rising edge with the node idle; returns at the same phase, node idle again.
   task automatic do_cmd(input string tag, input logic [DW-1:0] data, input logic [NC-1:0] mask,
                         input int ak, input logic [NC-1:0] em, input int ecyc, input bit eab,
                         input int elat, input int hold);
      bit got = 0;
      int lat = 0;
      req_valid = 1'b1;
      req_data  = data;
      req_mask  = mask;
      check({tag, " req_ready before accept"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 600; c++) begin
         abort = (c == ak);
         if (resp_valid) begin
            got = 1;
            lat = c + 1;
            break;
         end
         @(posedge clk); #1;
      end
      abort = 1'b0;
      if (!got) begin
         check({tag, " response timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " resp_mask"}, 32'(resp_mask), 32'(em));
      check({tag, " resp_cycles"}, 32'(resp_cycles), 32'(ecyc));
      check({tag, " resp_aborted"}, 32'(resp_aborted), 32'(eab));
      check({tag, " req_ready in report"}, 32'(req_ready), 32'd0);
      // Backpressure: a competing command and abort pulses must not disturb the held response.
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         req_data  = DW'($urandom_range(0, 255));
         req_mask  = NC'($urandom_range(1, 31));
         abort     = 1'b1;
         @(posedge clk); #1;
         check({tag, " held resp_valid"}, 32'(resp_valid), 32'd1);
         check({tag, " held req_ready"}, 32'(req_ready), 32'd0);
         check({tag, " held resp_mask"}, 32'(resp_mask), 32'(em));
         check({tag, " held resp_cycles"}, 32'(resp_cycles), 32'(ecyc));
         check({tag, " held resp_aborted"}, 32'(resp_aborted), 32'(eab));
      end
      abort      = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check({tag, " resp_valid after handshake"}, 32'(resp_valid), 32'd0);
      check({tag, " req_ready after handshake"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{8'd3,   5'b10101, -1, 5'b10101, 8,   1'b0, 9};
      vecs[1] = '{8'd9,   5'b00000, -1, 5'b00000, 0,   1'b0, 1};
      vecs[2] = '{8'd0,   5'b11111,  2, 5'b00111, 3,   1'b1, 4};
      vecs[3] = '{8'd0,   5'b11111,  4, 5'b11111, 5,   1'b0, 6};
      vecs[4] = '{8'd0,   5'b00001, -1, 5'b00001, 1,   1'b0, 2};
      vecs[5] = '{8'd255, 5'b10000, -1, 5'b10000, 260, 1'b0, 261};
      vecs[6] = '{8'd5,   5'b01010,  0, 5'b00000, 1,   1'b1, 2};

      // Reset and idle state.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset resp_mask", 32'(resp_mask), 32'd0);
      check("reset resp_cycles", 32'(resp_cycles), 32'd0);
      check("reset resp_aborted", 32'(resp_aborted), 32'd0);
      check("reset sat req_ready", 32'(s_req_ready), 32'd1);

      // Abort while idle is ignored.
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("idle abort req_ready", 32'(req_ready), 32'd1);
      check("idle abort resp_valid", 32'(resp_valid), 32'd0);

      foreach (vecs[k])
         do_cmd($sformatf("vec%0d", k), vecs[k].data, vecs[k].mask, vecs[k].ak,
                vecs[k].em, vecs[k].ecyc, vecs[k].eab, vecs[k].elat, 0);

      // Long backpressure, then the next command goes through normally.
      do_cmd("backpressure", 8'd3, 5'b10101, -1, 5'b10101, 8, 1'b0, 9, 10);
      do_cmd("after backpressure", 8'd1, 5'b00011, -1, 5'b00011, 3, 1'b0, 4, 0);

      // Reset in the middle of a run.
      req_valid = 1'b1;
      req_data  = 8'd20;
      req_mask  = 5'b11111;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrun reset req_ready", 32'(req_ready), 32'd1);
      check("midrun reset resp_valid", 32'(resp_valid), 32'd0);
      check("midrun reset resp_mask", 32'(resp_mask), 32'd0);
      check("midrun reset resp_cycles", 32'(resp_cycles), 32'd0);
      check("midrun reset resp_aborted", 32'(resp_aborted), 32'd0);
      // Stale active leaves would stretch this run.
      do_cmd("post reset", 8'd0, 5'b00001, -1, 5'b00001, 1, 1'b0, 2, 0);

      // Saturating counter on the 3-bit instance: 11 RUN cycles clamp to 7.
      begin
         bit got = 0;
         int lat = 0;
         s_req_valid = 1'b1;
         s_req_data  = 8'd10;
         s_req_mask  = 5'b00001;
         @(posedge clk); #1;
         s_req_valid = 1'b0;
         for (int c = 0; c < 100; c++) begin
            if (s_resp_valid) begin
               got = 1;
               lat = c + 1;
               break;
            end
            @(posedge clk); #1;
         end
         check("sat response seen", 32'(got), 32'd1);
         check("sat latency", 32'(lat), 32'd12);
         check("sat resp_cycles", 32'(s_resp_cycles), 32'd7);
         check("sat resp_mask", 32'(s_resp_mask), 32'd1);
         check("sat resp_aborted", 32'(s_resp_aborted), 32'd0);
         s_resp_ready = 1'b1;
         @(posedge clk); #1;
         s_resp_ready = 1'b0;
         check("sat idle after handshake", 32'(s_req_ready), 32'd1);
      end

      // Randomized commands against the model.
      for (int r = 0; r < 40; r++) begin
         logic [DW-1:0] d;
         logic [NC-1:0] m, em;
         int ak, ecyc, elat;
         bit eab;
         d  = DW'($urandom_range(0, 20));
         m  = NC'($urandom_range(0, 31));
         ak = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 25));
         model(int'(d), m, ak, em, ecyc, eab, elat);
         do_cmd($sformatf("rand%0d", r), d, m, ak, em, ecyc, eab, elat, int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
